hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the ID-stage forwarding logic and decides when each pipeline register may advance, when a bubble goes into ID/EX, and when IF/ID is flushed.
- Covers three cases forwarding cannot resolve: load-use hazards, taken branches/jumps resolved in ID, and variable-latency data-memory accesses.
- Includes a memory-wait timeout that locks the pipe into an error state.

Parameters:
- MEM_WAIT_MAX, 15: number of consecutive not-ready memory cycles that triggers a timeout (1..255).
- WAIT_CNT_W, 8: width of the memory-wait counter.
- STAT_W, 16: width of the performance counters (optional feature only).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- ID_Rs  input  5  rs of the instruction in ID.
- ID_Rt  input  5  rt of the instruction in ID.
- ID_UsesRt  input  1  rt is a true source operand (R-type, store, beq/bne).
- EX_MemRead  input  1  instruction in EX is a load.
- EX_Rw  input  5  destination register of the instruction in EX.
- ID_BranchTaken  input  1  branch/jump resolved taken in ID this cycle.
- MEM_Access  input  1  instruction in MEM performs a load or store.
- MemReady  input  1  data memory completes the access this cycle.
- PCWrite  output  1  PC may update.
- IFIDWrite  output  1  IF/ID register may update.
- IDEXBubble  output  1  load a NOP (all control bits zero) into ID/EX.
- IFFlush  output  1  clear IF/ID to NOP at the next edge.
- PipeFreeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- MemTimeout  output  1  sticky error flag.
- LoadStallCount  output  STAT_W  number of load-use stall cycles.
- FlushCount  output  STAT_W  number of IF/ID flushes.
- MemWaitCount  output  STAT_W  number of memory-wait cycles.

Behaviour:
- State register values: RUN, MEM_WAIT, ERROR. Reset forces RUN, wait counter 0, MemTimeout 0, stat counters 0.
- Outputs are combinational from state and inputs (zero latency). Default values: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFFlush=0, PipeFreeze=0.
- While Reset=1, outputs are: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFFlush=0, PipeFreeze=0.
- memwait condition: MEM_Access && !MemReady.
- loaduse condition: EX_MemRead && EX_Rw!=0 && (ID_Rs==EX_Rw || (ID_UsesRt && ID_Rt==EX_Rw)).
- Priority, highest first: ERROR > memwait > loaduse > ID_BranchTaken.
- RUN with memwait:
  - PCWrite=0, IFIDWrite=0, PipeFreeze=1.
  - No bubble, no flush.
  - Next state MEM_WAIT; wait counter := 1.
- RUN with loaduse and no memwait:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - IFFlush suppressed even if ID_BranchTaken=1, because the branch re-evaluates next cycle.
  - Exactly one bubble per hazard; the next cycle re-evaluates normally.
- RUN with ID_BranchTaken only: IFFlush=1; PC and IF/ID still write.
- MEM_WAIT:
  - Same freeze outputs as memwait (PCWrite=0, IFIDWrite=0, PipeFreeze=1); loaduse and branch are ignored.
  - If MemReady=1: outputs revert to RUN evaluation of the current inputs in the same cycle; next state RUN; counter cleared.
  - Else counter increments. When the counter would reach MEM_WAIT_MAX: next state ERROR and MemTimeout := 1.
- ERROR:
  - PCWrite=0, IFIDWrite=0, PipeFreeze=1, IDEXBubble=1.
  - Held until Reset; MemTimeout stays 1.
- Reset mid-wait: returns to RUN on the next edge; the counter and flag are cleared.
- MEM_WAIT_MAX=1: the first not-ready cycle in RUN goes directly to ERROR.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - LoadStallCount increments on each loaduse bubble cycle.
  - FlushCount increments on each IFFlush cycle.
  - MemWaitCount increments on each PipeFreeze cycle in RUN or MEM_WAIT.
  - All three saturate at all-ones and are cleared by Reset.
- Undefined: the three ports are present and tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum hz_state_t {HZ_RUN, HZ_MEM_WAIT, HZ_ERROR};
  - REG_ZERO=5'd0;
  - the NOP control-bundle constant used with IDEXBubble.
- One sub-module, sat_counter (parameter width, inc, clear), instantiated three times under HAZARD_STATS_EN.

Test Plan:
- lw $5 in EX (EX_MemRead=1, EX_Rw=5), ID_Rs=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle with EX_MemRead=0, all defaults; LoadStallCount=1.
- EX_Rw=0 with a load, ID_Rs=0 -> no stall. Load to $7, ID_Rt=7 with ID_UsesRt=0 -> no stall.
- ID_BranchTaken=1 with no hazard -> IFFlush=1 for one cycle, PCWrite=1. With a simultaneous loaduse -> IFFlush=0, IDEXBubble=1.
- MEM_Access=1, MemReady low for 3 cycles, then high -> PipeFreeze=1 for 3 cycles, released in the ready cycle; MemTimeout=0; MemWaitCount=3.
- MEM_WAIT_MAX=4 with MemReady held low -> ERROR entered after the 4th wait cycle, MemTimeout=1 and the freeze held. Then Reset=1 for one cycle -> RUN, MemTimeout=0, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard/stall controller: FSM states, register-zero id, ID/EX NOP bundle.
// Pure declarations: no latency, no flow control.
package hazard_pkg;

  typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_ERROR} hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic       jump;
    logic [2:0] aluOp;
  } idex_ctrl_t;

  // Control bundle muxed into ID/EX whenever IDEXBubble is asserted.
  localparam idex_ctrl_t IDEX_NOP = '0;

  function automatic logic loadUseHazard(
    input logic       exMemRead,
    input logic [4:0] exRw,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       idUsesRt
  );
    return exMemRead && (exRw != REG_ZERO) &&
           ((idRs == exRw) || (idUsesRt && (idRt == exRw)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; one count per cycle with inc high.
// Never wraps: holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/bubble/flush controller: load-use, ID-resolved branches, memory waits with timeout.
// Outputs are combinational (zero latency); HAZARD_STATS_EN adds saturating event counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 8,
  parameter int STAT_W       = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_Rw,
  input  logic              ID_BranchTaken,
  input  logic              MEM_Access,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXBubble,
  output logic              IFFlush,
  output logic              PipeFreeze,
  output logic              MemTimeout,
  output logic [STAT_W-1:0] LoadStallCount,
  output logic [STAT_W-1:0] FlushCount,
  output logic [STAT_W-1:0] MemWaitCount
);

  localparam logic [WAIT_CNT_W:0] WAIT_LIMIT = (WAIT_CNT_W + 1)'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W:0] WAIT_ONE   = (WAIT_CNT_W + 1)'(1);

  hz_state_t             state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic [WAIT_CNT_W:0]   waitNext;
  logic                  memWait;
  logic                  loadUse;
  logic                  evalRun;

  assign memWait  = MEM_Access && !MemReady;
  assign loadUse  = loadUseHazard(EX_MemRead, EX_Rw, ID_Rs, ID_Rt, ID_UsesRt);
  assign waitNext = {1'b0, waitCnt} + WAIT_ONE;
  // A wait that completes this cycle releases the pipe immediately.
  assign evalRun  = (state == HZ_RUN) || ((state == HZ_MEM_WAIT) && MemReady);

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFFlush    = 1'b0;
    PipeFreeze = 1'b0;
    if (Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (state == HZ_ERROR) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      PipeFreeze = 1'b1;
      IDEXBubble = 1'b1;
    end else if (!evalRun || memWait) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      PipeFreeze = 1'b1;
    end else if (loadUse) begin
      // Branch flush is dropped: the branch re-resolves once the load data is forwardable.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (ID_BranchTaken) begin
      IFFlush    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= HZ_RUN;
      waitCnt    <= '0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (memWait) begin
            waitCnt <= WAIT_ONE[WAIT_CNT_W-1:0];
            if (WAIT_ONE >= WAIT_LIMIT) begin
              state      <= HZ_ERROR;
              MemTimeout <= 1'b1;
            end else begin
              state <= HZ_MEM_WAIT;
            end
          end
        end
        HZ_MEM_WAIT: begin
          if (MemReady) begin
            state   <= HZ_RUN;
            waitCnt <= '0;
          end else if (waitNext >= WAIT_LIMIT) begin
            state      <= HZ_ERROR;
            MemTimeout <= 1'b1;
          end else begin
            waitCnt <= waitNext[WAIT_CNT_W-1:0];
          end
        end
        HZ_ERROR: state <= HZ_ERROR;
        default:  state <= HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic loadInc;
  logic waitInc;

  // Outside reset and ERROR, a bubble can only come from a load-use hazard.
  assign loadInc = IDEXBubble && !Reset && (state != HZ_ERROR);
  assign waitInc = PipeFreeze && (state != HZ_ERROR);

  sat_counter #(.WIDTH(STAT_W)) uLoadStall (
    .CLK(CLK), .clear(Reset), .inc(loadInc), .count(LoadStallCount)
  );
  sat_counter #(.WIDTH(STAT_W)) uFlush (
    .CLK(CLK), .clear(Reset), .inc(IFFlush), .count(FlushCount)
  );
  sat_counter #(.WIDTH(STAT_W)) uMemWait (
    .CLK(CLK), .clear(Reset), .inc(waitInc), .count(MemWaitCount)
  );
`else
  assign LoadStallCount = '0;
  assign FlushCount     = '0;
  assign MemWaitCount   = '0;
`endif

endmodule
